// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port block-RAM front end.
// The state encoding and grant encoding are visible to debug logic and checkers.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_VID = 1'b1;

  localparam int ACCESS_CYCLES = 4;

  // The RAM has no lane steering, so a byte write drives the byte on every lane.
  function automatic logic [31:0] replicate_byte(input logic [7:0] b);
    return {4{b}};
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational grant selector: one requester wins outright; on a tie, either
// fixed video priority or alternation against the previous grant.
module ram_arb_pick
  import ram_arbiter_pkg::*;
#(
  parameter bit VID_PRIO = 1'b0
) (
  input  logic i_cpu_req,
  input  logic i_vid_req,
  input  logic i_last_grant,
  output logic o_valid,
  output logic o_grant
);

  always_comb begin
    o_valid = i_cpu_req | i_vid_req;
    o_grant = GNT_CPU;
    if (i_cpu_req && i_vid_req) begin
      o_grant = VID_PRIO ? GNT_VID : ~i_last_grant;
    end else if (i_vid_req) begin
      o_grant = GNT_VID;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port front end for the 512 KB block RAM: arbitrates CPU and video ports
// and sequences each access through IDLE -> ACC1 -> ACC2 -> DONE.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int AW       = 19,
  parameter bit VID_PRIO = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  // Handshake: a requester raises req with stable command fields and holds
  // both until it sees the one-cycle ack; req is not sampled during DONE.
  input  logic          i_cpu_req,
  input  logic          i_cpu_wr,
  input  logic          i_cpu_be,
  input  logic [AW-1:0] i_cpu_adr,
  input  logic [31:0]   i_cpu_wdata,
  output logic [31:0]   o_cpu_rdata,
  output logic          o_cpu_ack,
  input  logic          i_vid_req,
  input  logic [AW-3:0] i_vid_adr,
  output logic [31:0]   o_vid_rdata,
  output logic          o_vid_ack,
  output logic          o_ram_wr,
  output logic          o_ram_be,
  output logic [AW-1:0] o_ram_adr,
  output logic [31:0]   o_ram_wdata,
  input  logic [31:0]   i_ram_rdata,
  output state_t        o_dbg_state
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_load;
  logic          w_finish;
  logic          w_pick_valid;
  logic          w_pick_grant;

  logic          r_grant;
  logic          r_ram_wr;
  logic          r_ram_be;
  logic [AW-1:0] r_ram_adr;
  logic [31:0]   r_ram_wdata;
  logic [31:0]   r_cpu_rdata;
  logic [31:0]   r_vid_rdata;
  logic          r_cpu_ack;
  logic          r_vid_ack;

  ram_arb_pick #(
    .VID_PRIO (VID_PRIO)
  ) u_pick (
    .i_cpu_req    (i_cpu_req),
    .i_vid_req    (i_vid_req),
    .i_last_grant (r_grant),
    .o_valid      (w_pick_valid),
    .o_grant      (w_pick_grant)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ACC1;
        end
      end
      ACC1: w_state_nxt = ACC2;
      ACC2: begin
        w_finish    = 1'b1;
        w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // r_grant doubles as last_grant: it is rewritten on every grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_grant     <= GNT_CPU;
      r_ram_wr    <= 1'b0;
      r_ram_be    <= 1'b0;
      r_ram_adr   <= '0;
      r_ram_wdata <= '0;
      r_cpu_rdata <= '0;
      r_vid_rdata <= '0;
      r_cpu_ack   <= 1'b0;
      r_vid_ack   <= 1'b0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_vid_ack <= 1'b0;
      if (w_load) begin
        r_grant <= w_pick_grant;
        if (w_pick_grant == GNT_CPU) begin
          r_ram_adr   <= i_cpu_adr;
          r_ram_be    <= i_cpu_be;
          r_ram_wr    <= i_cpu_wr;
          r_ram_wdata <= i_cpu_be ? replicate_byte(i_cpu_wdata[7:0]) : i_cpu_wdata;
        end else begin
          r_ram_adr <= {i_vid_adr, 2'b00};
          r_ram_be  <= 1'b0;
          r_ram_wr  <= 1'b0;
        end
      end
      // Write strobe spans ACC1 and ACC2 so one lands on an active RAM phase.
      if (w_finish) begin
        r_ram_wr <= 1'b0;
        if (r_grant == GNT_VID) begin
          r_vid_ack   <= 1'b1;
          r_vid_rdata <= i_ram_rdata;
        end else begin
          r_cpu_ack <= 1'b1;
          if (!r_ram_wr) begin
            r_cpu_rdata <= i_ram_rdata;
          end
        end
      end
    end
  end

  assign o_cpu_rdata = r_cpu_rdata;
  assign o_cpu_ack   = r_cpu_ack;
  assign o_vid_rdata = r_vid_rdata;
  assign o_vid_ack   = r_vid_ack;
  assign o_ram_wr    = r_ram_wr;
  assign o_ram_be    = r_ram_be;
  assign o_ram_adr   = r_ram_adr;
  assign o_ram_wdata = r_ram_wdata;
  assign o_dbg_state = r_state;

endmodule
